// File: rtl/pll_reset_sequencer.sv
// ---------------------------------------------------------------------------
// pll_reset_sequencer
//
// This block sequences the system resets from the iCE40 PLL clock and its
// lock flag. Both resets stay asserted until the synchronised lock flag has
// been high for LOCK_STABLE_CYCLES cycles. The bus/peripheral reset is then
// released, and the CPU reset follows STAGE_GAP_CYCLES later. Any low sample
// of the lock flag after WAIT_LOCK re-asserts both resets and restarts the
// sequence. Each of these lock-loss events increments a saturating counter.
//
// Optional feature macro: RSTSEQ_SW_RESET_EN
//   When it is defined, the sw_reset_req port exists. A request sampled in
//   STAGE or RUN re-asserts both resets and sends the FSM to STABILIZE, so
//   the lock-stable wait runs again.
//
// Ports
//   clock            in   system clock (PLL core output)
//   reset            in   asynchronous active-high reset
//   pll_locked       in   PLL lock flag, asynchronous to clock
//   clear_stats      in   synchronous clear of lock_lost_count
//   sw_reset_req     in   (RSTSEQ_SW_RESET_EN only) one-cycle sw reset request
//   bus_reset        out  active-high reset for bus and peripherals
//   cpu_reset        out  active-high reset for the CPU core
//   ready            out  high only in RUN
//   lock_lost_count  out  saturating count of lock-loss events
//
// The current FSM state is held in state_q, so checkers can probe it.
// ---------------------------------------------------------------------------
module pll_reset_sequencer #(
   parameter int LOCK_STABLE_CYCLES = 1024,
   parameter int STAGE_GAP_CYCLES   = 16,
   parameter int CNT_W              = 12
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       pll_locked,
   input  logic       clear_stats,
`ifdef RSTSEQ_SW_RESET_EN
   input  logic       sw_reset_req,
`endif
   output logic       bus_reset,
   output logic       cpu_reset,
   output logic       ready,
   output logic [7:0] lock_lost_count
);

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      STABILIZE = 2'd1,
      STAGE     = 2'd2,
      RUN       = 2'd3
   } state_t;

   // Terminal counts. The legal range goes up to 2^CNT_W, so value-1 always
   // fits in CNT_W bits.
   localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP_CYCLES - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       lost_q, lost_d;
   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             bus_q, bus_d;
   logic             cpu_q, cpu_d;
   logic             ready_q, ready_d;
   logic             locked_s;
   logic             lost_evt;
   logic             sw_req;

`ifdef RSTSEQ_SW_RESET_EN
   assign sw_req = sw_reset_req;
`else
   assign sw_req = 1'b0;
`endif

   assign locked_s = sync2_q;

   always_comb begin
      sync1_d  = pll_locked;
      sync2_d  = sync1_q;
      state_d  = state_q;
      cnt_d    = cnt_q;
      lost_evt = 1'b0;

      case (state_q)
         WAIT_LOCK: begin
            cnt_d = '0;
            if (locked_s) state_d = STABILIZE;
         end
         STABILIZE: begin
            if (!locked_s) begin
               state_d  = WAIT_LOCK;
               cnt_d    = '0;
               lost_evt = 1'b1;
            end else if (cnt_q == LOCK_LAST) begin
               state_d = STAGE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         STAGE: begin
            // Lock loss takes priority over a software request.
            if (!locked_s) begin
               state_d  = WAIT_LOCK;
               cnt_d    = '0;
               lost_evt = 1'b1;
            end else if (sw_req) begin
               state_d = STABILIZE;
               cnt_d   = '0;
            end else if (cnt_q == GAP_LAST) begin
               state_d = RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RUN: begin
            cnt_d = '0;
            if (!locked_s) begin
               state_d  = WAIT_LOCK;
               lost_evt = 1'b1;
            end else if (sw_req) begin
               state_d = STABILIZE;
            end
         end
         default: begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
         end
      endcase

      // clear_stats wins over an increment in the same cycle.
      lost_d = lost_q;
      if (clear_stats)
         lost_d = 8'd0;
      else if (lost_evt && (lost_q != 8'hFF))
         lost_d = lost_q + 8'd1;

      // The outputs are decoded from the next state, so each one changes on
      // the same edge as the state.
      bus_d   = (state_d == WAIT_LOCK) || (state_d == STABILIZE);
      cpu_d   = (state_d != RUN);
      ready_d = (state_d == RUN);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         state_q <= WAIT_LOCK;
         cnt_q   <= '0;
         lost_q  <= 8'd0;
         bus_q   <= 1'b1;
         cpu_q   <= 1'b1;
         ready_q <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         lost_q  <= lost_d;
         bus_q   <= bus_d;
         cpu_q   <= cpu_d;
         ready_q <= ready_d;
      end
   end

   assign bus_reset       = bus_q;
   assign cpu_reset       = cpu_q;
   assign ready           = ready_q;
   assign lock_lost_count = lost_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// ---------------------------------------------------------------------------
// Directed testbench for pll_reset_sequencer. The DUT is built with
// LOCK_STABLE_CYCLES = 8 and STAGE_GAP_CYCLES = 4.
//
// Stimulus and sampling both happen 1 ns after each rising edge. Edge counts
// therefore line up with the DUT's registered outputs.
//
// Handshake: there is no valid/ready pair. Inputs are level signals. The bench
// changes them only just after a rising edge, and the DUT samples them on the
// next edge.
// ---------------------------------------------------------------------------
module tb_pll_reset_sequencer;

   logic       clock;
   logic       reset;
   logic       pll_locked;
   logic       clear_stats;
`ifdef RSTSEQ_SW_RESET_EN
   logic       sw_reset_req;
`endif
   logic       bus_reset;
   logic       cpu_reset;
   logic       ready;
   logic [7:0] lock_lost_count;

   int checks = 0;
   int errors = 0;

   pll_reset_sequencer #(
      .LOCK_STABLE_CYCLES(8),
      .STAGE_GAP_CYCLES  (4),
      .CNT_W             (12)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .pll_locked     (pll_locked),
      .clear_stats    (clear_stats),
`ifdef RSTSEQ_SW_RESET_EN
      .sw_reset_req   (sw_reset_req),
`endif
      .bus_reset      (bus_reset),
      .cpu_reset      (cpu_reset),
      .ready          (ready),
      .lock_lost_count(lock_lost_count)
   );

   // ---- clock / reset ----
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // ---- driver tasks ----
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Returns the number of edges until bus_reset falls, or -1 if it does not
   // fall within the budget.
   task automatic wait_bus_fall(input int budget, output int n);
      n = -1;
      for (int i = 1; i <= budget; i++) begin
         tick();
         if (bus_reset === 1'b0) begin
            n = i;
            break;
         end
      end
   endtask

   // One lock-loss event that starts from a non-WAIT_LOCK state. The loss is
   // registered on the third edge. The FSM then sits in STABILIZE again.
   task automatic lose_once();
      pll_locked = 1'b0;
      tick();
      pll_locked = 1'b1;
      repeat (5) tick();
   endtask

   // ---- scenarios ----
   task automatic test_reset();
      reset = 1'b1; pll_locked = 1'b0; clear_stats = 1'b0;
      repeat (5) tick();
      checks++; if (bus_reset !== 1'b1) begin errors++; $display("FAIL rst_bus got %b exp 1", bus_reset); end
      checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL rst_cpu got %b exp 1", cpu_reset); end
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", ready); end
      checks++; if (lock_lost_count !== 8'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", lock_lost_count); end
      reset = 1'b0;
      repeat (20) tick();
      checks++; if (bus_reset !== 1'b1) begin errors++; $display("FAIL hold_bus got %b exp 1", bus_reset); end
      checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL hold_cpu got %b exp 1", cpu_reset); end
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL hold_ready got %b exp 0", ready); end
   endtask

   task automatic test_lock_acquire();
      int n;
      pll_locked = 1'b1;
      wait_bus_fall(20, n);
      checks++; if (n != 11 && n != 12) begin errors++; $display("FAIL acq_bus_edge got %0d exp 11 or 12", n); end
      checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL acq_cpu_stage got %b exp 1", cpu_reset); end
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL acq_ready_stage got %b exp 0", ready); end
      repeat (3) tick();
      checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL acq_cpu_gap3 got %b exp 1", cpu_reset); end
      tick();
      checks++; if (cpu_reset !== 1'b0) begin errors++; $display("FAIL acq_cpu_gap4 got %b exp 0", cpu_reset); end
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL acq_ready_gap4 got %b exp 1", ready); end
      checks++; if (bus_reset !== 1'b0) begin errors++; $display("FAIL acq_bus_run got %b exp 0", bus_reset); end
   endtask

   task automatic test_lock_glitch();
      int n;
      pll_locked = 1'b0;
      tick();                 // edge 1
      pll_locked = 1'b1;
      tick();                 // edge 2: the loss is not yet visible
      checks++; if (bus_reset !== 1'b0) begin errors++; $display("FAIL glitch_bus_e2 got %b exp 0", bus_reset); end
      tick();                 // edge 3
      checks++; if (bus_reset !== 1'b1) begin errors++; $display("FAIL glitch_bus_e3 got %b exp 1", bus_reset); end
      checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL glitch_cpu_e3 got %b exp 1", cpu_reset); end
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL glitch_ready_e3 got %b exp 0", ready); end
      checks++; if (lock_lost_count !== 8'd1) begin errors++; $display("FAIL glitch_count got %0d exp 1", lock_lost_count); end
      // The lock returned after edge 1, so bus_reset falls at edge 12.
      wait_bus_fall(20, n);
      checks++; if (n != 9) begin errors++; $display("FAIL glitch_refall got %0d exp 9", n); end
      repeat (4) tick();
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL glitch_ready_run got %b exp 1", ready); end
   endtask

   task automatic test_saturate_clear();
      repeat (253) lose_once();
      checks++; if (lock_lost_count !== 8'd254) begin errors++; $display("FAIL sat_254 got %0d exp 254", lock_lost_count); end
      repeat (7) lose_once();
      checks++; if (lock_lost_count !== 8'd255) begin errors++; $display("FAIL sat_255 got %0d exp 255", lock_lost_count); end
      // Assert clear_stats on the same edge as another loss increment.
      pll_locked = 1'b0;
      tick();                 // edge 1
      pll_locked = 1'b1;
      tick();                 // edge 2
      clear_stats = 1'b1;
      tick();                 // edge 3: loss and clear together
      clear_stats = 1'b0;
      checks++; if (lock_lost_count !== 8'd0) begin errors++; $display("FAIL clear_prio got %0d exp 0", lock_lost_count); end
      checks++; if (bus_reset !== 1'b1) begin errors++; $display("FAIL clear_bus got %b exp 1", bus_reset); end
      repeat (3) tick();
      lose_once();
      checks++; if (lock_lost_count !== 8'd1) begin errors++; $display("FAIL count_after_clear got %0d exp 1", lock_lost_count); end
      clear_stats = 1'b1;
      tick();
      clear_stats = 1'b0;
      checks++; if (lock_lost_count !== 8'd0) begin errors++; $display("FAIL clear_alone got %0d exp 0", lock_lost_count); end
      lose_once();            // leaves the count at 1
   endtask

   task automatic test_async_reset();
      int n;
      wait_bus_fall(20, n);
      checks++; if (n < 0) begin errors++; $display("FAIL ar_reach_stage got %0d exp >0", n); end
      repeat (2) tick();
      checks++; if (lock_lost_count !== 8'd1) begin errors++; $display("FAIL ar_pre_count got %0d exp 1", lock_lost_count); end
      reset = 1'b1;
      #1;                     // between edges, so no clock edge has occurred
      checks++; if (bus_reset !== 1'b1) begin errors++; $display("FAIL ar_bus got %b exp 1", bus_reset); end
      checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL ar_cpu got %b exp 1", cpu_reset); end
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL ar_ready got %b exp 0", ready); end
      checks++; if (lock_lost_count !== 8'd0) begin errors++; $display("FAIL ar_count got %0d exp 0", lock_lost_count); end
      repeat (2) tick();
      reset = 1'b0;
      wait_bus_fall(30, n);
      checks++; if (n != 11) begin errors++; $display("FAIL ar_restart got %0d exp 11", n); end
      repeat (4) tick();
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL ar_ready_run got %b exp 1", ready); end
   endtask

`ifdef RSTSEQ_SW_RESET_EN
   task automatic test_sw_reset();
      int n;
      sw_reset_req = 1'b1;
      tick();
      sw_reset_req = 1'b0;
      checks++; if (bus_reset !== 1'b1) begin errors++; $display("FAIL sw_bus got %b exp 1", bus_reset); end
      checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL sw_cpu got %b exp 1", cpu_reset); end
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL sw_ready got %b exp 0", ready); end
      checks++; if (lock_lost_count !== 8'd0) begin errors++; $display("FAIL sw_count got %0d exp 0", lock_lost_count); end
      wait_bus_fall(20, n);
      checks++; if (n != 8) begin errors++; $display("FAIL sw_refall got %0d exp 8", n); end
      repeat (4) tick();
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL sw_ready_run got %b exp 1", ready); end
   endtask
`endif

   // ---- sequence and report ----
   initial begin
      reset       = 1'b1;
      pll_locked  = 1'b0;
      clear_stats = 1'b0;
`ifdef RSTSEQ_SW_RESET_EN
      sw_reset_req = 1'b0;
`endif
      test_reset();
      test_lock_acquire();
      test_lock_glitch();
      test_saturate_clear();
      test_async_reset();
`ifdef RSTSEQ_SW_RESET_EN
      test_sw_reset();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Reset sequencer driven by the iCE40 PLL output clock and lock flag. Outputs stay in reset until the PLL lock has been stable for a programmable time. Resets are then released in two stages: bus/peripherals first, CPU core second. Any loss of lock re-asserts both resets immediately and restarts the sequence, and each such event is counted for debug.

## Interface
- `LOCK_STABLE_CYCLES`, default 1024: cycles `pll_locked` must stay high (after synchronisation) before `bus_reset` releases; legal 1..2^CNT_W.
- `STAGE_GAP_CYCLES`, default 16: cycles between `bus_reset` release and `cpu_reset` release; legal 1..2^CNT_W.
- `CNT_W`, default 12: width of the shared delay counter.
- `clock` in 1: system clock, the PLL core output (48 MHz).
- `reset` in 1: asynchronous, active-high reset (power-on / button).
- `pll_locked` in 1: PLL lock flag; asynchronous to `clock`.
- `clear_stats` in 1: synchronous; clears `lock_lost_count`.
- `sw_reset_req` in 1: present only with `RSTSEQ_SW_RESET_EN`; single-cycle software reset request.
- `bus_reset` out 1: active-high reset for bus and peripherals.
- `cpu_reset` out 1: active-high reset for the CPU core.
- `ready` out 1: high only in RUN.
- `lock_lost_count` out 8: saturating count of lock-loss events.

## Operation
- `pll_locked` passes through a 2-flop synchroniser to give `locked_s`. Synchroniser flops reset to 0.
- The FSM has states WAIT_LOCK, STABILIZE, STAGE, RUN. Reset state is WAIT_LOCK.
- **WAIT_LOCK:** both resets = 1, `ready` = 0, counter = 0. When `locked_s` = 1, go to STABILIZE.
- **STABILIZE:** counter increments each cycle. When counter = LOCK_STABLE_CYCLES-1, clear the counter and go to STAGE.
- **STAGE:** `bus_reset` = 0, `cpu_reset` = 1. Counter increments. When counter = STAGE_GAP_CYCLES-1, go to RUN.
- **RUN:** both resets = 0, `ready` = 1. The FSM stays here until lock is lost.
- **Lock loss:** in STABILIZE, STAGE or RUN, `locked_s` = 0 for any single cycle sends the FSM to WAIT_LOCK. There is no glitch filter; any low sample restarts the sequence.
- **`lock_lost_count`:**
  - Increments when that lock-loss transition happens, and saturates at 255.
  - `clear_stats` loads 0 and takes priority over an increment in the same cycle.
- **Outputs:** all outputs are registered and decoded from the next state, so each output changes on the same edge as the state change.
- **Reset mid-operation:** `reset` high forces `bus_reset` = `cpu_reset` = 1, `ready` = 0, state WAIT_LOCK, counter 0 and `lock_lost_count` 0. This takes effect asynchronously, in any state.

## Timing
- Reset values: `bus_reset` = 1, `cpu_reset` = 1, `ready` = 0, `lock_lost_count` = 0.
- Assertion is asynchronous on `reset`. Deassertion is always synchronous to `clock`.
- `pll_locked` rise to `bus_reset` fall: 2 + 1 + LOCK_STABLE_CYCLES rising edges (synchroniser, WAIT_LOCK exit, stabilise count). Allow +1 edge for synchroniser uncertainty.
- `bus_reset` fall to `cpu_reset` fall: exactly STAGE_GAP_CYCLES edges. `ready` rises on the same edge as `cpu_reset` falls.
- `pll_locked` fall to both resets = 1: 3 edges (2 synchroniser + 1 registered output).
- `lock_lost_count` updates on that same edge.
- `clear_stats` takes effect 1 edge after it is sampled high.

## Configuration
- Macro: `RSTSEQ_SW_RESET_EN`.
- **Defined:**
  - The `sw_reset_req` port exists.
  - A high sample in STAGE or RUN forces both resets = 1 and `ready` = 0 on the next edge, and moves the FSM to STABILIZE with counter 0. The lock-stable wait is therefore repeated.
  - The request does not increment `lock_lost_count`.
  - The request is ignored in WAIT_LOCK and STABILIZE.
  - Lock loss has priority over a simultaneous request.
- **Undefined:** the port is absent, and reset sequencing is driven only by `reset` and `pll_locked`.

## Test plan
Bench parameters: LOCK_STABLE_CYCLES = 8, STAGE_GAP_CYCLES = 4.
1. **Power-up:** `reset` high for 5 cycles, `pll_locked` = 0. Required: `bus_reset` = `cpu_reset` = 1, `ready` = 0, `lock_lost_count` = 0, held indefinitely.
2. **Lock acquisition:** raise `pll_locked` at edge 0. Required: `bus_reset` falls at edge 11 (12 acceptable); `cpu_reset` falls and `ready` rises exactly 4 edges later.
3. **Lock glitch in RUN:** drop `pll_locked` for 1 cycle. Required: both resets = 1 three edges later and `lock_lost_count` = 1. The full sequence then repeats, with `bus_reset` falling 11 edges after `locked` returns.
4. **Saturation and clear:** cause 260 lock-loss events. Required: `lock_lost_count` = 255. Then pulse `clear_stats` coincident with another loss event. Required: count = 0.
5. **Async reset mid-STAGE:** assert `reset` 2 cycles after `bus_reset` falls. Required: `bus_reset` = 1 with no clock edge, and `lock_lost_count` = 0. After release with lock held, the sequence restarts from WAIT_LOCK.
6. **Software reset (`RSTSEQ_SW_RESET_EN` defined):**
   - 1-cycle `sw_reset_req` in RUN. Required: both resets = 1 and `ready` = 0 next edge; `bus_reset` falls 8 edges later; `lock_lost_count` unchanged.
   - Without the macro: the port is absent and the build still elaborates.
